lse_reduce_seq: RTL and testbench



---
 rtl/lse_reduce_seq_if.sv | 27 ++
 rtl/lse_reduce_seq.sv | 177 +++++++++++++++++
 tb/tb_lse_reduce_seq.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lse_reduce_seq_if.sv
// Valid/ready input beat stream and reduced-result output stream of lse_reduce_seq.
interface lse_reduce_seq_if #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned CNT_WIDTH = 10
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     out_data;
   logic [CNT_WIDTH-1:0] out_count;
   logic                 out_err;

   // Producer / consumer side seen by the environment
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count, out_err
   );

   // Reducer side
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count, out_err
   );
endinterface

// File: rtl/lse_reduce_seq.sv
// Log-sum-exp vector reducer: accumulates a valid/ready beat stream through
// lse_acc and presents one registered result per vector (in_last or MAX_LEN).
// Word format: bit WIDTH-1 is the sign of the linear value, the remaining bits
// are a two's-complement log2 magnitude with FRAC_BITS fraction bits; the most
// negative magnitude code (16'h4000 at the default width) encodes -inf.
module lse_reduce_seq #(
   parameter int unsigned INT_BITS  = 12,
   parameter int unsigned FRAC_BITS = 3,
   parameter int unsigned WIDTH     = INT_BITS + FRAC_BITS + 1,
   parameter int unsigned MAX_LEN   = 256,
   parameter int unsigned CNT_WIDTH = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clear,
   lse_reduce_seq_if.slave bus
);
   localparam logic [WIDTH-1:0] NEG_INF = {2'b01, {(WIDTH-2){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 in_ready_q, in_ready_d;
   logic                 out_valid_q, out_valid_d;
   logic [WIDTH-1:0]     out_data_q, out_data_d;
   logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
   logic                 out_err_q, out_err_d;

   logic [WIDTH-1:0]     sum;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic                 beat;
   logic                 at_max;

   lse_acc #(
      .INT_BITS  (INT_BITS),
      .FRAC_BITS (FRAC_BITS),
      .WIDTH     (WIDTH)
   ) u_lse_acc (
      .accumulator_in (acc_q),
      .addend_in      (bus.in_data),
      .sum            (sum)
   );

   // Next-state, accumulator and output-register logic
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      out_err_d   = out_err_q;
      cnt_inc     = cnt_q + CNT_WIDTH'(1);
      beat        = bus.in_valid && in_ready_q;
      at_max      = (cnt_inc == CNT_WIDTH'(MAX_LEN));

      case (state_q)
         IDLE, ACCUM: begin
            if (beat) begin
               acc_d   = sum;
               cnt_d   = cnt_inc;
               state_d = ACCUM;
               if (bus.in_last || at_max) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  out_data_d  = sum;
                  out_count_d = cnt_inc;
                  out_err_d   = at_max && !bus.in_last;
               end
            end
         end
         DONE: begin
            if (out_valid_q && bus.out_ready) begin
               state_d     = IDLE;
               acc_d       = NEG_INF;
               cnt_d       = '0;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort wins over everything, including a beat or handshake this cycle
      if (clear) begin
         state_d     = IDLE;
         acc_d       = NEG_INF;
         cnt_d       = '0;
         out_valid_d = 1'b0;
      end

      // Registered copy of the state decode keeps out_ready off the in_ready path
      in_ready_d = (state_d != DONE);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= NEG_INF;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= NEG_INF;
         out_count_q <= '0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         out_err_q   <= out_err_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_count = out_count_q;
   assign bus.out_err   = out_err_q;
endmodule

// Combinational log-domain adder: sum = log2(2^a +/- 2^b) with a piecewise-
// linear correction term (1.0 - d/2 for d < 2.0, else 0) applied to the larger
// operand; added for equal signs, subtracted for opposite signs. The result
// takes the sign of the larger operand (accumulator on a tie). Results below
// the smallest finite code become -inf; results above the largest saturate.
module lse_acc #(
   parameter int unsigned INT_BITS  = 12,
   parameter int unsigned FRAC_BITS = 3,
   parameter int unsigned WIDTH     = INT_BITS + FRAC_BITS + 1
) (
   input  logic [WIDTH-1:0] accumulator_in,
   input  logic [WIDTH-1:0] addend_in,
   output logic [WIDTH-1:0] sum
);
   localparam int unsigned          LW          = WIDTH - 1;
   localparam int unsigned          EW          = WIDTH + 1;
   localparam logic [LW-1:0]        LOG_NEG_INF = {1'b1, {(LW-1){1'b0}}};
   localparam logic signed [EW-1:0] ONE         = EW'(1 << FRAC_BITS);
   localparam logic signed [EW-1:0] LOG_MAX     = EW'((1 << (LW - 1)) - 1);
   localparam logic signed [EW-1:0] LOG_MIN     = -LOG_MAX;

   logic signed [EW-1:0] la, lb, hi, diff, corr, res;
   logic                 a_big;
   logic                 res_sign;

   // Max-plus-correction datapath with -inf bypass and range clamping
   always_comb begin
      la       = EW'($signed(accumulator_in[LW-1:0]));
      lb       = EW'($signed(addend_in[LW-1:0]));
      a_big    = (la >= lb);
      hi       = a_big ? la : lb;
      diff     = a_big ? (la - lb) : (lb - la);
      res_sign = a_big ? accumulator_in[LW] : addend_in[LW];
      corr     = (diff < (ONE <<< 1)) ? (ONE - (diff >>> 1)) : '0;
      res      = (accumulator_in[LW] == addend_in[LW]) ? (hi + corr) : (hi - corr);

      if (accumulator_in[LW-1:0] == LOG_NEG_INF) begin
         sum = addend_in;
      end else if (addend_in[LW-1:0] == LOG_NEG_INF) begin
         sum = accumulator_in;
      end else if (res > LOG_MAX) begin
         sum = {res_sign, LOG_MAX[LW-1:0]};
      end else if (res < LOG_MIN) begin
         sum = {1'b0, LOG_NEG_INF};
      end else begin
         sum = {res_sign, res[LW-1:0]};
      end
   end
endmodule

// File: tb/tb_lse_reduce_seq.sv
// Directed + randomized bench for lse_reduce_seq (MAX_LEN=4) with an output scoreboard.
module tb_lse_reduce_seq;
   localparam int unsigned WIDTH     = 16;
   localparam int unsigned CNT_WIDTH = 10;
   localparam int unsigned MAX_LEN   = 4;
   localparam logic [15:0] NINF      = 16'h4000;

   typedef struct packed {
      logic [15:0] data;
      logic [9:0]  count;
      logic        err;
   } exp_t;

   logic clk;
   logic rst_n;
   logic clear;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   lse_reduce_seq_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

   lse_reduce_seq #(
      .INT_BITS  (12),
      .FRAC_BITS (3),
      .WIDTH     (WIDTH),
      .MAX_LEN   (MAX_LEN),
      .CNT_WIDTH (CNT_WIDTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: log2(2^a +/- 2^b) with correction max(0, 1 - d/2) in 1/8 units
   function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
      int   la, lb, hi, d, c, r;
      logic s;
      la = int'(a[13:0]) - (a[14] ? 16384 : 0);
      lb = int'(b[13:0]) - (b[14] ? 16384 : 0);
      if (la == -16384) return b;
      if (lb == -16384) return a;
      if (la >= lb) begin
         hi = la; d = la - lb; s = a[15];
      end else begin
         hi = lb; d = lb - la; s = b[15];
      end
      c = (d < 16) ? (8 - d / 2) : 0;
      r = (a[15] == b[15]) ? hi + c : hi - c;
      if (r > 16383) r = 16383;
      if (r < -16383) return NINF;
      return {s, r[14:0]};
   endfunction

   // Present one beat at posedge+1, hold until accepted, return at posedge+1
   task automatic send(input logic [15:0] d, input logic last);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      @(negedge clk);
      while (!bus.in_ready && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("accept_wait", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // Wait until every expected result has been seen and the output is idle
   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((sb.size() != 0 || bus.out_valid) && n < 60) begin
         n++;
         @(negedge clk);
      end
      chk("drain_wait", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_out_data"},  32'(bus.out_data),  32'(NINF));
      chk({tag, "_out_count"}, 32'(bus.out_count), 32'd0);
      chk({tag, "_out_err"},   32'(bus.out_err),   32'd0);
      chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
   endtask

   // Scoreboard: compare each output handshake against the oldest expectation
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_output: observed data %0h count %0d err %0b with empty scoreboard",
                   bus.out_data, bus.out_count, bus.out_err);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_data",  32'(bus.out_data),  32'(e.data));
            chk("out_count", 32'(bus.out_count), 32'(e.count));
            chk("out_err",   32'(bus.out_err),   32'(e.err));
         end
      end
   end

   initial begin
      logic [15:0] pool [8];
      logic [15:0] acc;
      logic [15:0] v;
      int          len;
      logic        last;

      pool[0] = 16'h0010; pool[1] = 16'h0050; pool[2] = 16'h8030; pool[3] = NINF;
      pool[4] = 16'h0123; pool[5] = 16'h8008; pool[6] = 16'h0014; pool[7] = 16'h7FF0;

      rst_n        = 1'b0;
      clear        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 16'h0000;
      bus.in_last  = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

      // Single terminal beat, result held until out_ready
      bus.out_ready = 1'b0;
      sb.push_back('{16'h0050, 10'd1, 1'b0});
      send(16'h0050, 1'b1);
      chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_in_ready",  32'(bus.in_ready),  32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("t1_hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      wait_idle();

      // Two equal beats: log2(4+4) = 3.0
      sb.push_back('{16'h0018, 10'd2, 1'b0});
      send(16'h0010, 1'b0);
      chk("t2_no_early_valid", 32'(bus.out_valid), 32'd0);
      send(16'h0010, 1'b1);
      chk("t2_out_valid", 32'(bus.out_valid), 32'd1);
      wait_idle();

      // -inf beats count but do not change the sum; opposite-sign subtraction
      sb.push_back('{16'h0123, 10'd3, 1'b0});
      send(NINF, 1'b0);
      send(16'h0123, 1'b0);
      send(NINF, 1'b1);
      wait_idle();
      sb.push_back('{16'h0008, 10'd2, 1'b0});
      send(16'h0010, 1'b0);
      send(16'h8010, 1'b1);
      wait_idle();

      // Forced termination at MAX_LEN without in_last, then with in_last coinciding
      sb.push_back('{16'h001E, 10'd4, 1'b1});
      repeat (4) send(16'h0010, 1'b0);
      chk("t4_err_valid", 32'(bus.out_valid), 32'd1);
      wait_idle();
      sb.push_back('{16'h001E, 10'd4, 1'b0});
      repeat (3) send(16'h0010, 1'b0);
      send(16'h0010, 1'b1);
      wait_idle();

      // Backpressure: result stable, nothing consumed, 1-cycle turnaround after release
      bus.out_ready = 1'b0;
      sb.push_back('{16'h0030, 10'd1, 1'b0});
      send(16'h0030, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0040;
      bus.in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_out_data",  32'(bus.out_data),  32'h0030);
         chk("bp_out_count", 32'(bus.out_count), 32'd1);
         chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      sb.push_back('{16'h0040, 10'd1, 1'b0});
      @(negedge clk);
      chk("bp_release_in_ready_0", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      chk("bp_release_in_ready_1", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
      wait_idle();

      // Clear mid-vector drops partial sum and the beat presented with it
      send(16'h0010, 1'b0);
      send(16'h0010, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0070;
      bus.in_last  = 1'b1;
      clear        = 1'b1;
      @(posedge clk); #1;
      clear        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      @(negedge clk);
      chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
      chk("clr_in_ready",  32'(bus.in_ready),  32'd1);
      sb.push_back('{16'h0020, 10'd1, 1'b0});
      @(posedge clk); #1;
      send(16'h0020, 1'b1);
      wait_idle();

      // Clear while a result is pending discards it
      bus.out_ready = 1'b0;
      send(16'h0055, 1'b1);
      chk("clr_done_valid_before", 32'(bus.out_valid), 32'd1);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk("clr_done_valid_after", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Reset mid-vector: reset values while low, identical result afterwards
      send(16'h0010, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("rst_mid");
      @(posedge clk); #1;
      chk_reset_outputs("rst_mid_hold");
      rst_n = 1'b1;
      @(posedge clk); #1;
      sb.push_back('{16'h0020, 10'd1, 1'b0});
      send(16'h0020, 1'b1);
      wait_idle();

      // Reset while a result is pending
      bus.out_ready = 1'b0;
      send(16'h0066, 1'b1);
      chk("rst_done_valid_before", 32'(bus.out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("rst_done");
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;

      // Randomized vectors checked against the reference model
      for (int k = 0; k < 24; k++) begin
         len = int'($urandom_range(1, 4));
         acc = NINF;
         for (int i = 0; i < len; i++) begin
            v    = (($urandom_range(0, 4) == 0) ? 16'(($urandom_range(0, 1) << 15) | $urandom_range(0, 16'h0200))
                                                 : pool[$urandom_range(0, 7)]);
            acc  = model_add(acc, v);
            last = (i == len - 1) && !(len == 4 && $urandom_range(0, 1) == 1);
            if (i == len - 1) sb.push_back('{acc, 10'(len), (len == 4) && !last});
            send(v, last);
         end
         if ($urandom_range(0, 2) == 0) wait_idle();
      end
      wait_idle();

      chk("final_scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
